// File: rtl/channel_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : channel_packer_if
// Brief    : Channel handshake bundle (data, valid, accept) of width W.
// Revision : 1.0 - initial release
// ============================================================================
interface channel_packer_if #(
    parameter int W = 10
);
    logic [W-1:0] d;
    logic         v;
    logic         a;

    modport master (output d, output v, input  a);
    modport slave  (input  d, input  v, output a);
endinterface
`default_nettype wire

// File: rtl/channel_packer.sv
`default_nettype none
// ============================================================================
// Module   : channel_packer
// Brief    : Packs up to K NIN-bit Channel words into one count-tagged word,
//            flushing partial words after an idle timeout.
//            Optional manual flush port: define CHANNEL_PACKER_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module channel_packer #(
    parameter int NIN     = 10,
    parameter int K       = 3,
    parameter int TIMEOUT = 16
) (
    input  wire logic clk,
    input  wire logic reset_n,
`ifdef CHANNEL_PACKER_FLUSH_EN
    input  wire logic flush,
`endif
    channel_packer_if.slave  in,
    channel_packer_if.master out
);
    localparam int CW = $clog2(K + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] c_tmo_last  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] c_last_lane = CW'(K - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_timer;
    logic [K*NIN-1:0] r_lanes;

    logic w_fill;
    logic w_accept;
    logic w_has;
    logic w_full;
    logic w_tmo;
    logic w_flush;
    logic w_go_send;

`ifdef CHANNEL_PACKER_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_fill    = (r_state == ST_FILL);
    assign in.a      = w_fill & in.v & reset_n;
    assign w_accept  = w_fill & in.v;
    assign w_has     = (r_cnt != '0);
    assign w_full    = w_accept && (r_cnt == c_last_lane);
    // An accept in the expiry cycle takes priority over the timeout flush.
    assign w_tmo     = (TIMEOUT != 0) && w_has && !w_accept && (r_timer == c_tmo_last);
    assign w_go_send = w_fill && (w_full || w_tmo || (w_flush && w_has));

    assign out.v = (r_state == ST_SEND);
    assign out.d = {r_cnt, r_lanes};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_timer <= '0;
            r_lanes <= '0;
        end else begin
            case (r_state)
                ST_FILL: begin
                    if (w_accept) begin
                        for (int i = 0; i < K; i++) begin
                            if (r_cnt == CW'(i)) begin
                                r_lanes[i*NIN +: NIN] <= in.d;
                            end
                        end
                        r_cnt   <= r_cnt + CW'(1);
                        r_timer <= '0;
                    end else if (w_has && (r_timer != '1)) begin
                        r_timer <= r_timer + TW'(1);
                    end
                    if (w_go_send) begin
                        r_state <= ST_SEND;
                        r_timer <= '0;
                    end
                end
                ST_SEND: begin
                    // Clearing lanes here keeps partial words free of stale data.
                    if (out.a) begin
                        r_state <= ST_FILL;
                        r_cnt   <= '0;
                        r_timer <= '0;
                        r_lanes <= '0;
                    end
                end
                default: r_state <= ST_FILL;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_channel_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_channel_packer
// Brief    : Directed self-checking bench for channel_packer (K=3, NIN=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_channel_packer;
    localparam int NIN  = 10;
    localparam int K    = 3;
    localparam int TMO  = 4;
    localparam int CW   = $clog2(K + 1);
    localparam int NOUT = CW + K * NIN;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;

    channel_packer_if #(.W(NIN))  in_if ();
    channel_packer_if #(.W(NOUT)) out_if ();
    channel_packer_if #(.W(NIN))  in0_if ();
    channel_packer_if #(.W(NOUT)) out0_if ();

    channel_packer #(.NIN(NIN), .K(K), .TIMEOUT(TMO)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef CHANNEL_PACKER_FLUSH_EN
        .flush   (flush),
`endif
        .in      (in_if.slave),
        .out     (out_if.master)
    );

    // Same geometry with the timeout disabled: a lone word must never leave.
    channel_packer #(.NIN(NIN), .K(K), .TIMEOUT(0)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef CHANNEL_PACKER_FLUSH_EN
        .flush   (1'b0),
`endif
        .in      (in0_if.slave),
        .out     (out0_if.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    logic [31:0] exp_d;

    initial begin
        in_if.v   = 1'b1;
        in_if.d   = 10'h3FF;
        out_if.a  = 1'b1;
        in0_if.v  = 1'b0;
        in0_if.d  = '0;
        out0_if.a = 1'b1;

        // Reset state
        neg();
        chk("reset_ina", 32'(in_if.a), 32'd0);
        chk("reset_v",   32'(out_if.v), 32'd0);
        chk("reset_d",   out_if.d, 32'd0);
        adv();
        reset_n  = 1'b1;
        in_if.v  = 1'b0;

        // Full pack: 1,2,3 back to back
        in_if.v = 1'b1;
        in_if.d = 10'h001;
        neg();
        chk("t1_ina", 32'(in_if.a), 32'd1);
        adv();
        in_if.d = 10'h002;
        adv();
        in_if.d = 10'h003;
        adv();
        in_if.d = 10'h004;
        neg();
        chk("t1_v",   32'(out_if.v), 32'd1);
        chk("t1_d",   out_if.d, 32'hC030_0801);
        chk("t1_ina0", 32'(in_if.a), 32'd0);
        adv();
        in_if.v = 1'b0;
        neg();
        chk("t1_vfall", 32'(out_if.v), 32'd0);

        // Timeout after 4 idle cycles; TIMEOUT=0 instance holds its word
        in_if.v  = 1'b1;
        in_if.d  = 10'h155;
        in0_if.v = 1'b1;
        in0_if.d = 10'h155;
        adv();
        in_if.v  = 1'b0;
        in0_if.v = 1'b0;
        adv(); adv(); adv();
        neg();
        chk("t2_early", 32'(out_if.v), 32'd0);
        adv();
        neg();
        chk("t2_v", 32'(out_if.v), 32'd1);
        chk("t2_d", out_if.d, 32'h4000_0155);
        chk("t2_tmo0", 32'(out0_if.v), 32'd0);
        repeat (20) adv();
        neg();
        chk("t2_tmo0_late", 32'(out0_if.v), 32'd0);
        chk("t2_back_fill", 32'(out_if.v), 32'd0);

        // Backpressure: 10 cycles held in SEND with input pending
        out_if.a = 1'b0;
        in_if.v  = 1'b1;
        in_if.d  = 10'h011;
        adv();
        in_if.d  = 10'h022;
        adv();
        in_if.d  = 10'h033;
        adv();
        in_if.d  = 10'h3AA;
        exp_d    = {2'd3, 10'h033, 10'h022, 10'h011};
        for (int i = 0; i < 10; i++) begin
            neg();
            chk("t3_ina_hold", 32'(in_if.a), 32'd0);
            chk("t3_d_hold",   out_if.d, exp_d);
            adv();
        end
        out_if.a = 1'b1;
        adv();
        neg();
        chk("t3_ina_resume", 32'(in_if.a), 32'd1);
        adv();
        in_if.v  = 1'b0;
        out_if.a = 1'b0;
        adv(); adv(); adv();
        neg();
        chk("t3_early", 32'(out_if.v), 32'd0);
        adv();
        neg();
        chk("t3_lane0", out_if.d, 32'h4000_03AA);
        out_if.a = 1'b1;
        adv();

        // Timer race: accept in the expiry cycle
        in_if.v = 1'b1;
        in_if.d = 10'h001;
        adv();
        in_if.v = 1'b0;
        adv(); adv(); adv();
        in_if.v = 1'b1;
        in_if.d = 10'h002;
        adv();
        in_if.v = 1'b0;
        neg();
        chk("t4_noflush", 32'(out_if.v), 32'd0);
        adv(); adv(); adv();
        neg();
        chk("t4_restart", 32'(out_if.v), 32'd0);
        adv();
        neg();
        chk("t4_v", 32'(out_if.v), 32'd1);
        chk("t4_d", out_if.d, 32'h8000_0801);
        adv();

        // Reset while a word is pending
        out_if.a = 1'b0;
        in_if.v  = 1'b1;
        in_if.d  = 10'h0C1;
        adv();
        in_if.d  = 10'h0C2;
        adv();
        in_if.d  = 10'h0C3;
        adv();
        in_if.d  = 10'h0AB;
        neg();
        chk("t5_v", 32'(out_if.v), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_vrst",  32'(out_if.v), 32'd0);
        chk("t5_drst",  out_if.d, 32'd0);
        chk("t5_inarst", 32'(in_if.a), 32'd0);
        adv();
        reset_n  = 1'b1;
        out_if.a = 1'b1;
        adv();
        in_if.v = 1'b0;
        adv(); adv(); adv(); adv();
        neg();
        chk("t5_first", out_if.d, 32'h4000_00AB);
        adv();

`ifdef CHANNEL_PACKER_FLUSH_EN
        // Manual flush: ignored when empty, includes a same-cycle accept
        flush = 1'b1;
        adv();
        flush = 1'b0;
        neg();
        chk("t6_empty", 32'(out_if.v), 32'd0);
        in_if.v = 1'b1;
        in_if.d = 10'h155;
        adv();
        in_if.d = 10'h3FF;
        flush   = 1'b1;
        adv();
        in_if.v = 1'b0;
        flush   = 1'b0;
        exp_d   = {2'd2, 10'h000, 10'h3FF, 10'h155};
        neg();
        chk("t6_v", 32'(out_if.v), 32'd1);
        chk("t6_d", out_if.d, exp_d);
        adv();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
